// File: rtl/ahb_ifetch_master_pkg.sv
// Shared AHB-Lite encodings and the instruction-fetch FSM state type.
package ahb_ifetch_master_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_ERR  = 2'b11
   } ifetch_state_t;

endpackage

// File: rtl/ahb_ifetch_master.sv
// Read-only AHB-Lite instruction fetcher: one single-beat word read in flight,
// owns the fetch PC and hands back each instruction with its address.
module ahb_ifetch_master
   import ahb_ifetch_master_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0004
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              fetch_err,
   output logic              busy,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   input  logic              HREADY,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HRESP
);

   ifetch_state_t     r_state, w_state_nxt;
   htrans_t           r_htrans, w_htrans_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [ADDR_W-1:0] r_haddr, w_haddr_nxt;
   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_instr_valid, w_instr_valid_nxt;
   logic              r_fetch_err, w_fetch_err_nxt;
   logic              r_drop_pending, w_drop_nxt;
   logic              w_load_instr;
   logic [ADDR_W-1:0] w_redir_pc;

   assign w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

   always_comb begin
      w_state_nxt       = r_state;
      w_htrans_nxt      = r_htrans;
      w_pc_nxt          = r_pc;
      w_haddr_nxt       = r_haddr;
      w_drop_nxt        = r_drop_pending;
      w_instr_valid_nxt = 1'b0;
      w_fetch_err_nxt   = 1'b0;
      w_load_instr      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_htrans_nxt = HTRANS_IDLE;
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
            end else begin
               w_pc_nxt = r_pc;
            end
            if (fetch_req) begin
               w_haddr_nxt  = redirect_valid ? w_redir_pc : r_pc;
               w_htrans_nxt = HTRANS_NONSEQ;
               w_state_nxt  = ST_ADDR;
            end else begin
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               w_htrans_nxt = HTRANS_IDLE;
               w_state_nxt  = ST_DATA;
            end else begin
               w_state_nxt  = ST_ADDR;
            end
         end
         ST_DATA: begin
            // A slave that errors without the two-cycle handshake is still an error completion.
            if (HRESP == HRESP_ERROR) begin
               if (HREADY) begin
                  w_fetch_err_nxt = 1'b1;
                  w_drop_nxt      = 1'b0;
                  w_state_nxt     = ST_IDLE;
               end else begin
                  w_state_nxt     = ST_ERR;
               end
            end else if (HREADY) begin
               if (!r_drop_pending && !redirect_valid) begin
                  w_instr_valid_nxt = 1'b1;
                  w_load_instr      = 1'b1;
                  w_pc_nxt          = r_pc + ADDR_W'(4);
               end else begin
                  w_instr_valid_nxt = 1'b0;
               end
               w_drop_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_ERR: begin
            if (HREADY) begin
               w_fetch_err_nxt = 1'b1;
               w_drop_nxt      = 1'b0;
               w_state_nxt     = ST_IDLE;
            end else begin
               w_state_nxt     = ST_ERR;
            end
         end
         default: begin
            w_htrans_nxt = HTRANS_IDLE;
            w_state_nxt  = ST_IDLE;
         end
      endcase
      // Mid-transfer redirect: the bus beat still finishes, but its data belongs to the old PC.
      if (redirect_valid && (r_state != ST_IDLE)) begin
         w_pc_nxt   = w_redir_pc;
         w_drop_nxt = (w_state_nxt != ST_IDLE);
      end else begin
         w_drop_nxt = w_drop_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= ST_IDLE;
         r_htrans       <= HTRANS_IDLE;
         r_pc           <= RESET_PC;
         r_haddr        <= '0;
         r_instr        <= '0;
         r_instr_pc     <= '0;
         r_instr_valid  <= 1'b0;
         r_fetch_err    <= 1'b0;
         r_drop_pending <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_htrans       <= w_htrans_nxt;
         r_pc           <= w_pc_nxt;
         r_haddr        <= w_haddr_nxt;
         r_instr_valid  <= w_instr_valid_nxt;
         r_fetch_err    <= w_fetch_err_nxt;
         r_drop_pending <= w_drop_nxt;
         if (w_load_instr) begin
            r_instr    <= HRDATA;
            r_instr_pc <= r_haddr;
         end else begin
            r_instr    <= r_instr;
            r_instr_pc <= r_instr_pc;
         end
      end
   end

   assign instr_valid = r_instr_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign fetch_err   = r_fetch_err;
   assign busy        = (r_state != ST_IDLE);
   assign HADDR       = r_haddr;
   assign HTRANS      = r_htrans;
   assign HWRITE      = 1'b0;
   assign HSIZE       = HSIZE_WORD;
   assign HBURST      = HBURST_SINGLE;

endmodule

// File: tb/tb_ahb_ifetch_master.sv
// Scoreboard bench for ahb_ifetch_master: tasks play the ROM slave and queue
// expected bus addresses and completions; a negedge monitor pops and compares.
module tb_ahb_ifetch_master;

   typedef struct {
      bit          is_err;
      logic [31:0] data;
      logic [31:0] pc;
      int          cyc;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_req = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fetch_err;
   logic        busy;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic        HREADY = 1'b1;
   logic [31:0] HRDATA = 32'h0;
   logic        HRESP = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [31:0] exp_addr_q[$];
   resp_t       exp_resp_q[$];

   ahb_ifetch_master dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .fetch_err(fetch_err), .busy(busy),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: address phases and completion pulses against the queued expectations.
   always @(negedge clk) begin
      if (reset && HTRANS == 2'b10 && HREADY) begin
         if (exp_addr_q.size() == 0) begin
            check("unexpected_addr_phase", 64'(HADDR), 64'hDEAD);
         end else begin
            check("haddr", 64'(HADDR), 64'(exp_addr_q.pop_front()));
            check("hwrite_hsize_hburst", 64'({HWRITE, HSIZE, HBURST}), 64'({1'b0, 3'b010, 3'b000}));
         end
      end
      if (instr_valid === 1'b1 || fetch_err === 1'b1) begin
         if (exp_resp_q.size() == 0) begin
            check("unexpected_pulse", 64'({instr_valid, fetch_err}), 64'h0);
         end else begin
            resp_t r;
            r = exp_resp_q.pop_front();
            check("pulse_kind", 64'({instr_valid, fetch_err}), 64'({!r.is_err, r.is_err}));
            check("pulse_cycle", 64'(cyc), 64'(r.cyc));
            if (!r.is_err) begin
               check("instr", 64'(instr), 64'(r.data));
               check("instr_pc", 64'(instr_pc), 64'(r.pc));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One fetch transaction, starting and ending in IDLE at #1 after a posedge.
   task automatic do_fetch(input logic [31:0] exp_a, input logic [31:0] data, input int waits,
                           input bit err, input bit redir_idle, input logic [31:0] idle_pc,
                           input bit redir_data);
      resp_t r;
      int    c0;
      c0 = cyc;
      exp_addr_q.push_back(exp_a);
      r.is_err = err;
      r.data   = data;
      r.pc     = exp_a;
      r.cyc    = c0 + 3 + waits + (err ? 1 : 0);
      if (!redir_data) exp_resp_q.push_back(r);
      fetch_req = 1'b1;
      if (redir_idle) begin
         redirect_valid = 1'b1;
         redirect_pc    = idle_pc;
      end
      tick();
      fetch_req      = 1'b0;
      redirect_valid = 1'b0;
      HREADY         = 1'b1;
      tick();
      check("busy_in_data", 64'(busy), 64'h1);
      for (int i = 0; i < waits; i++) begin
         HREADY = 1'b0;
         if (redir_data && i == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0040;
         end
         tick();
         redirect_valid = 1'b0;
      end
      if (err) begin
         HRESP  = 1'b1;
         HREADY = 1'b0;
         tick();
         HREADY = 1'b1;
         tick();
      end else begin
         HREADY = 1'b1;
         HRDATA = data;
         tick();
      end
      HRESP  = 1'b0;
      HREADY = 1'b1;
      HRDATA = 32'hBAD0_BAD0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      check("reset_htrans", 64'(HTRANS), 64'h0);
      check("reset_haddr", 64'(HADDR), 64'h0);
      check("reset_instr_valid", 64'(instr_valid), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_fetch_err", 64'(fetch_err), 64'h0);

      do_fetch(32'h0000_0004, 32'h0020_8113, 0, 1'b0, 1'b0, 32'h0, 1'b0);
      do_fetch(32'h0000_0008, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0, 1'b0);
      do_fetch(32'h0000_000C, 32'h0040_A203, 3, 1'b0, 1'b0, 32'h0, 1'b0);
      do_fetch(32'h0000_0010, 32'h0,         0, 1'b1, 1'b0, 32'h0, 1'b0);
      do_fetch(32'h0000_0010, 32'hCAFE_0010, 1, 1'b0, 1'b0, 32'h0, 1'b0);
      do_fetch(32'h0000_0018, 32'h0000_0018, 0, 1'b0, 1'b1, 32'h0000_001B, 1'b0);
      do_fetch(32'h0000_001C, 32'h5555_5555, 1, 1'b0, 1'b0, 32'h0, 1'b1);
      do_fetch(32'h0000_0040, 32'h0000_0040, 0, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (2) tick();
      check("idle_after_fetch_busy", 64'(busy), 64'h0);

      // Reset while the data phase is stalled.
      exp_addr_q.push_back(32'h0000_0044);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      HREADY = 1'b0;
      reset  = 1'b0;
      tick();
      reset  = 1'b1;
      HREADY = 1'b1;
      check("midreset_busy", 64'(busy), 64'h0);
      check("midreset_htrans", 64'(HTRANS), 64'h0);
      check("midreset_haddr", 64'(HADDR), 64'h0);
      repeat (2) tick();
      do_fetch(32'h0000_0004, 32'hA5A5_0004, 0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Idle redirect without fetch, then wrap around the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      do_fetch(32'hFFFF_FFFC, 32'h0BAD_F00D, 0, 1'b0, 1'b0, 32'h0, 1'b0);
      do_fetch(32'h0000_0000, 32'h0000_0013, 2, 1'b0, 1'b0, 32'h0, 1'b0);

      repeat (3) tick();
      check("addr_queue_drained", 64'(exp_addr_q.size()), 64'h0);
      check("resp_queue_drained", 64'(exp_resp_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
